// File: rtl/simd_alu_adder_pipe.sv
// Two-stage pipelined SIMD add/subtract unit with per-lane overflow/underflow flags.
// Define SIMD_ADDER_SAT_EN to add the 'sat' input and saturating results.
module simd_alu_adder_pipe #(
    parameter int DATA_WIDTH = 256,
    parameter int MODE_WIDTH = 3,
    localparam int NUM_BYTES = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [MODE_WIDTH-1:0] data_mode,
    input  logic                  data_signed,
    input  logic                  sub,
`ifdef SIMD_ADDER_SAT_EN
    input  logic                  sat,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [NUM_BYTES-1:0]  ovf,
    output logic [NUM_BYTES-1:0]  udf,
    output logic                  mode_err
);

    localparam int MAX_MODE  = $clog2(NUM_BYTES);
    localparam int NUM_MODES = MAX_MODE + 1;

    logic                  s1Valid_q;
    logic [DATA_WIDTH-1:0] s1A_q;
    logic [DATA_WIDTH-1:0] s1B_q;
    logic [MODE_WIDTH-1:0] s1Mode_q;
    logic                  s1Signed_q;
    logic                  s1Sub_q;
`ifdef SIMD_ADDER_SAT_EN
    logic                  s1Sat_q;
`endif

    logic                  s2Valid_q;
    logic [DATA_WIDTH-1:0] s2Res_q,  s2Res_d;
    logic [NUM_BYTES-1:0]  s2Ovf_q,  s2Ovf_d;
    logic [NUM_BYTES-1:0]  s2Udf_q,  s2Udf_d;
    logic                  s2Err_q,  s2Err_d;

    logic s1Advance;

    // Stage 1 may move forward whenever stage 2 is empty or draining this cycle.
    assign s1Advance = !s2Valid_q || out_ready;
    assign in_ready  = !s1Valid_q || s1Advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
        end else if (in_ready) begin
            s1Valid_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1A_q      <= a;
            s1B_q      <= b;
            s1Mode_q   <= data_mode;
            s1Signed_q <= data_signed;
            s1Sub_q    <= sub;
`ifdef SIMD_ADDER_SAT_EN
            s1Sat_q    <= sat;
`endif
        end
    end

    logic [NUM_MODES*DATA_WIDTH-1:0] allRes;
    logic [NUM_MODES*NUM_BYTES-1:0]  allOvf;
    logic [NUM_MODES*NUM_BYTES-1:0]  allUdf;

    // Every legal lane width is evaluated in parallel; the registered mode picks one.
    for (genvar m = 0; m < NUM_MODES; m++) begin : g_mode
        localparam int W  = 8 << m;
        localparam int NB = W / 8;
        for (genvar l = 0; l < DATA_WIDTH / W; l++) begin : g_lane
            logic [W-1:0] aL, bL, bEff, laneRes;
            logic [W:0]   sum;
            logic         laneOvf, laneUdf;

            assign aL = s1A_q[l*W +: W];
            assign bL = s1B_q[l*W +: W];

            always_comb begin
                bEff = s1Sub_q ? ~bL : bL;
                sum  = {1'b0, aL} + {1'b0, bEff} + (W+1)'(s1Sub_q);
                if (s1Signed_q) begin
                    laneOvf = !aL[W-1] && !bEff[W-1] &&  sum[W-1];
                    laneUdf =  aL[W-1] &&  bEff[W-1] && !sum[W-1];
                end else begin
                    laneOvf = !s1Sub_q &&  sum[W];
                    laneUdf =  s1Sub_q && !sum[W];
                end
                laneRes = sum[W-1:0];
`ifdef SIMD_ADDER_SAT_EN
                if (s1Sat_q && laneOvf) begin
                    laneRes = s1Signed_q ? {1'b0, {(W-1){1'b1}}} : {W{1'b1}};
                end else if (s1Sat_q && laneUdf) begin
                    laneRes = s1Signed_q ? {1'b1, {(W-1){1'b0}}} : {W{1'b0}};
                end
`endif
            end

            assign allRes[m*DATA_WIDTH + l*W +: W]   = laneRes;
            assign allOvf[m*NUM_BYTES + l*NB +: NB]  = NB'(laneOvf) << (NB - 1);
            assign allUdf[m*NUM_BYTES + l*NB +: NB]  = NB'(laneUdf) << (NB - 1);
        end
    end

    always_comb begin
        s2Res_d = '0;
        s2Ovf_d = '0;
        s2Udf_d = '0;
        s2Err_d = 1'b1;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (s1Mode_q == MODE_WIDTH'(m)) begin
                s2Res_d = allRes[m*DATA_WIDTH +: DATA_WIDTH];
                s2Ovf_d = allOvf[m*NUM_BYTES +: NUM_BYTES];
                s2Udf_d = allUdf[m*NUM_BYTES +: NUM_BYTES];
                s2Err_d = 1'b0;
            end
        end
    end

    // Stage 2 holds its payload while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2Valid_q <= 1'b0;
            s2Res_q   <= '0;
            s2Ovf_q   <= '0;
            s2Udf_q   <= '0;
            s2Err_q   <= 1'b0;
        end else if (s1Advance) begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2Res_q <= s2Res_d;
                s2Ovf_q <= s2Ovf_d;
                s2Udf_q <= s2Udf_d;
                s2Err_q <= s2Err_d;
            end
        end
    end

    assign out_valid = s2Valid_q;
    assign result    = s2Res_q;
    assign ovf       = s2Ovf_q;
    assign udf       = s2Udf_q;
    assign mode_err  = s2Err_q;

endmodule

// File: tb/tb_simd_alu_adder_pipe.sv
// Randomised and directed bench for simd_alu_adder_pipe with an arithmetic reference model.
// Honours SIMD_ADDER_SAT_EN when the design is built with it.
module tb_simd_alu_adder_pipe;

    localparam int DW = 256;
    localparam int MW = 3;
    localparam int NB = 32;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [MW-1:0] mode;
        logic          sgn;
        logic          sub;
        logic          sat;
    } opT;

    typedef struct {
        logic [DW-1:0] res;
        logic [NB-1:0] ovf;
        logic [NB-1:0] udf;
        logic          err;
    } expT;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] a, b, result;
    logic [MW-1:0] data_mode;
    logic          data_signed, sub, mode_err;
    logic [NB-1:0] ovf, udf;
`ifdef SIMD_ADDER_SAT_EN
    logic          sat;
`endif

    int  assertCount = 0;
    int  failCount   = 0;
    expT expQ[$];
    opT  curOp;

    logic          gotIn, gotOut, obsInReady, obsOutValid, obsErr;
    logic [DW-1:0] obsRes;
    logic [NB-1:0] obsOvf, obsUdf;
    logic          stallPrev = 1'b0;
    logic [DW-1:0] holdRes;
    logic [NB-1:0] holdOvf, holdUdf;
    logic          holdErr;

    simd_alu_adder_pipe #(.DATA_WIDTH(DW), .MODE_WIDTH(MW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .data_mode   (data_mode),
        .data_signed (data_signed),
        .sub         (sub),
`ifdef SIMD_ADDER_SAT_EN
        .sat         (sat),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .ovf         (ovf),
        .udf         (udf),
        .mode_err    (mode_err)
    );

    always #5 clk = ~clk;

    // Lanes are treated as plain integers; flags come from range checks on the exact sum.
    function automatic expT refModel(input opT op);
        expT e;
        logic signed [259:0] one, mask, av, bv, tv, wr, maxV, minV, acc;
        int w;
        e.res = '0;
        e.ovf = '0;
        e.udf = '0;
        e.err = 1'b0;
        if (op.mode > 3'd5) begin
            e.err = 1'b1;
            return e;
        end
        w    = 8 << op.mode;
        one  = 1;
        mask = (one << w) - one;
        acc  = '0;
        for (int lane = 0; lane < DW / w; lane++) begin
            av = ({4'b0, op.a} >> (lane * w)) & mask;
            bv = ({4'b0, op.b} >> (lane * w)) & mask;
            if (op.sgn) begin
                if (av[w-1]) av = av - (one << w);
                if (bv[w-1]) bv = bv - (one << w);
                maxV = (one << (w - 1)) - one;
                minV = -(one << (w - 1));
            end else begin
                maxV = mask;
                minV = '0;
            end
            tv = op.sub ? av - bv : av + bv;
            wr = tv;
            if (tv > maxV) begin
                e.ovf[(lane + 1) * w / 8 - 1] = 1'b1;
`ifdef SIMD_ADDER_SAT_EN
                if (op.sat) wr = maxV;
`endif
            end
            if (tv < minV) begin
                e.udf[(lane + 1) * w / 8 - 1] = 1'b1;
`ifdef SIMD_ADDER_SAT_EN
                if (op.sat) wr = minV;
`endif
            end
            acc = acc | ((wr & mask) << (lane * w));
        end
        e.res = acc[DW-1:0];
        return e;
    endfunction

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic opT mkOp(input logic [DW-1:0] oa, input logic [DW-1:0] ob,
                                input logic [MW-1:0] md, input logic sg,
                                input logic sb, input logic st);
        opT o;
        o.a = oa; o.b = ob; o.mode = md; o.sgn = sg; o.sub = sb; o.sat = st;
        return o;
    endfunction

    function automatic opT randOp();
        logic [MW-1:0] md;
        md = ($urandom_range(0, 9) < 8) ? MW'($urandom_range(0, 5)) : MW'($urandom_range(6, 7));
        return mkOp(rand256(), rand256(), md, 1'($urandom), 1'($urandom), 1'($urandom));
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input opT op, input logic valid);
        curOp       = op;
        a           = op.a;
        b           = op.b;
        data_mode   = op.mode;
        data_signed = op.sgn;
        sub         = op.sub;
`ifdef SIMD_ADDER_SAT_EN
        sat         = op.sat;
`endif
        in_valid    = valid;
    endtask

    // One clock: observe handshakes on the falling edge, score outputs, then step past the rising edge.
    task automatic cycle();
        expT e;
        @(negedge clk);
        gotIn       = 1'b0;
        gotOut      = 1'b0;
        obsInReady  = in_ready;
        obsOutValid = out_valid;
        obsRes      = result;
        obsOvf      = ovf;
        obsUdf      = udf;
        obsErr      = mode_err;
        if (rst) begin
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("hold_valid",  DW'(out_valid), DW'(1));
                checkOutput("hold_result", result, holdRes);
                checkOutput("hold_ovf",    DW'(ovf), DW'(holdOvf));
                checkOutput("hold_udf",    DW'(udf), DW'(holdUdf));
                checkOutput("hold_err",    DW'(mode_err), DW'(holdErr));
            end
            if (out_valid && out_ready) begin
                gotOut = 1'b1;
                if (expQ.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $error("[TB] FAIL unexpected_output observed result=%h expected no output", result);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sb_result", result, e.res);
                    checkOutput("sb_ovf",    DW'(ovf), DW'(e.ovf));
                    checkOutput("sb_udf",    DW'(udf), DW'(e.udf));
                    checkOutput("sb_err",    DW'(mode_err), DW'(e.err));
                end
            end
            stallPrev = out_valid && !out_ready;
            holdRes   = result;
            holdOvf   = ovf;
            holdUdf   = udf;
            holdErr   = mode_err;
            if (in_valid && in_ready) begin
                gotIn = 1'b1;
                expQ.push_back(refModel(curOp));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runDirected(input opT op, input string tag, input logic [DW-1:0] expRes,
                               input logic [NB-1:0] expOvf, input logic [NB-1:0] expUdf,
                               input logic expErr);
        int lat;
        lat = 0;
        out_ready = 1'b1;
        applyStimulus(op, 1'b1);
        cycle();
        checkOutput({tag, "_accept"}, DW'(gotIn), DW'(1));
        applyStimulus(op, 1'b0);
        for (int i = 1; i <= 6 && lat == 0; i++) begin
            cycle();
            if (gotOut) lat = i;
        end
        checkOutput({tag, "_latency"}, DW'(lat), DW'(2));
        checkOutput({tag, "_result"}, obsRes, expRes);
        checkOutput({tag, "_ovf"}, DW'(obsOvf), DW'(expOvf));
        checkOutput({tag, "_udf"}, DW'(obsUdf), DW'(expUdf));
        checkOutput({tag, "_err"}, DW'(obsErr), DW'(expErr));
    endtask

    initial begin
        opT o1, o2, o3;
        logic [DW-1:0] t3a, t3b, t3r;
        logic          satBit;

        rst       = 1'b1;
        out_ready = 1'b0;
        applyStimulus(mkOp('0, '0, '0, 1'b0, 1'b0, 1'b0), 1'b0);
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        checkOutput("reset_out_valid", DW'(obsOutValid), DW'(0));
        checkOutput("reset_in_ready",  DW'(obsInReady), DW'(1));
        checkOutput("reset_result",    obsRes, '0);
        checkOutput("reset_ovf",       DW'(obsOvf), DW'(0));
        checkOutput("reset_udf",       DW'(obsUdf), DW'(0));
        checkOutput("reset_err",       DW'(obsErr), DW'(0));

        runDirected(mkOp(DW'(8'hF0), DW'(8'h20), 3'd0, 1'b0, 1'b0, 1'b0), "m0_uadd",
                    DW'(8'h10), NB'(1), '0, 1'b0);

`ifdef SIMD_ADDER_SAT_EN
        satBit = 1'b1;
        runDirected(mkOp(DW'(32'h8000_0000), DW'(32'h0100_0000), 3'd0, 1'b1, 1'b1, satBit),
                    "m0_ssub_sat", DW'(32'h8000_0000), '0, NB'(32'h8), 1'b0);
`else
        satBit = 1'b0;
        runDirected(mkOp(DW'(32'h8000_0000), DW'(32'h0100_0000), 3'd0, 1'b1, 1'b1, satBit),
                    "m0_ssub", DW'(32'h7F00_0000), '0, NB'(32'h8), 1'b0);
`endif

        t3a = DW'(64'h7FFF_FFFF_FFFF_FFFF) << 64;
        t3b = DW'(1) << 64;
        t3r = DW'(64'h8000_0000_0000_0000) << 64;
        runDirected(mkOp(t3a, t3b, 3'd3, 1'b1, 1'b0, 1'b0), "m3_sadd",
                    t3r, NB'(32'h0000_8000), '0, 1'b0);

        runDirected(mkOp('0, DW'(1), 3'd5, 1'b0, 1'b1, 1'b0), "m5_usub",
                    '1, '0, NB'(32'h8000_0000), 1'b0);

        runDirected(mkOp(rand256(), rand256(), 3'd6, 1'b1, 1'b0, 1'b0), "m6_illegal",
                    '0, '0, '0, 1'b1);

        // Backpressure: two accepts fill the pipe, the third waits until the output drains.
        o1 = randOp(); o2 = randOp(); o3 = randOp();
        out_ready = 1'b0;
        applyStimulus(o1, 1'b1);
        cycle();
        checkOutput("bp_accept1", DW'(gotIn), DW'(1));
        applyStimulus(o2, 1'b1);
        cycle();
        checkOutput("bp_accept2", DW'(gotIn), DW'(1));
        applyStimulus(o3, 1'b1);
        cycle();
        checkOutput("bp_in_ready_low", DW'(obsInReady), DW'(0));
        checkOutput("bp_no_accept3",   DW'(gotIn), DW'(0));
        cycle();
        checkOutput("bp_still_low", DW'(obsInReady), DW'(0));
        out_ready = 1'b1;
        cycle();
        checkOutput("bp_shift_ready", DW'(obsInReady), DW'(1));
        checkOutput("bp_shift_in",    DW'(gotIn), DW'(1));
        checkOutput("bp_shift_out",   DW'(gotOut), DW'(1));
        applyStimulus(o3, 1'b0);
        repeat (4) cycle();
        checkOutput("bp_drained", DW'(expQ.size()), DW'(0));

        // Reset with both stages occupied discards everything in flight.
        out_ready = 1'b0;
        applyStimulus(randOp(), 1'b1);
        cycle();
        applyStimulus(randOp(), 1'b1);
        cycle();
        rst       = 1'b1;
        out_ready = 1'b1;
        applyStimulus(randOp(), 1'b1);
        cycle();
        rst = 1'b0;
        expQ.delete();
        in_valid = 1'b0;
        cycle();
        checkOutput("rst_full_out_valid", DW'(obsOutValid), DW'(0));
        checkOutput("rst_full_in_ready",  DW'(obsInReady), DW'(1));
        checkOutput("rst_full_result",    obsRes, '0);
        checkOutput("rst_full_flags",     DW'({obsOvf, obsUdf, obsErr}), DW'(0));
        repeat (4) cycle();

        for (int i = 0; i < 400; i++) begin
            if (!in_valid || gotIn) applyStimulus(randOp(), 1'($urandom_range(0, 9) < 7));
            out_ready = 1'($urandom_range(0, 9) < 7);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) cycle();
        checkOutput("final_drained", DW'(expQ.size()), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
